// File: rtl/lms_da_pkg.sv
// rtl/lms_da_pkg.sv - shared defaults, state encoding and helpers for the DA LMS shift-accumulate stage
package lms_da_pkg;

  localparam int DW_DEF   = 8;
  localparam int BITS_DEF = 8;
  localparam int AW_DEF   = 20;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Slice counter width; a single-slice sample still needs one counter bit.
  function automatic int ctr_w(input int bits);
    return (bits > 1) ? $clog2(bits) : 1;
  endfunction

endpackage

// File: rtl/da_shift_accum_if.sv
// rtl/da_shift_accum_if.sv - partial-sum input, slice control and result bundle of the shift-accumulate stage
interface da_shift_accum_if
  import lms_da_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
);

  logic                 start;
  logic                 in_valid;
  logic signed [DW-1:0] p2;
  logic signed [DW-1:0] p3;
  logic signed [DW-1:0] p4;
  logic signed [DW-1:0] p5;
  logic [2:0]           t;
  logic                 sign;
  logic                 busy;
  logic signed [AW-1:0] acc2;
  logic signed [AW-1:0] acc3;
  logic signed [AW-1:0] acc4;
  logic signed [AW-1:0] acc5;
  logic signed [AW-1:0] total;
  logic                 out_valid;

  modport master (
    output start, in_valid, p2, p3, p4, p5,
    input  t, sign, busy, acc2, acc3, acc4, acc5, total, out_valid
  );

  modport slave (
    input  start, in_valid, p2, p3, p4, p5,
    output t, sign, busy, acc2, acc3, acc4, acc5, total, out_valid
  );

endinterface

// File: rtl/da_slice_ctr.sv
// rtl/da_slice_ctr.sv - bit-slice counter with clear, enable, last-slice flag and t/sign outputs
module da_slice_ctr
  import lms_da_pkg::*;
#(
  parameter int BITS = BITS_DEF,
  parameter int CW   = ctr_w(BITS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic          active_i,
  output logic [CW-1:0] cnt_o,
  output logic          last_o,
  output logic [2:0]    t_o,
  output logic          sign_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign last_o = (cnt_q == CW'(BITS - 1));

  // Wrap to zero after the last slice so the next sample starts clean.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = last_o ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign t_o    = 3'(cnt_q);
  assign sign_o = active_i & last_o;

endmodule

// File: rtl/da_shift_accum.sv
// rtl/da_shift_accum.sv - sequences one sample's bit-slices and shift-accumulates four signed partial sums
module da_shift_accum
  import lms_da_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int BITS = BITS_DEF,
  parameter int AW   = AW_DEF
) (
  input logic             clk,
  input logic             rst,
  da_shift_accum_if.slave bus
);

  localparam int CW = ctr_w(BITS);

  state_t               state_q;
  logic [CW-1:0]        cnt;
  logic                 last;
  logic                 slice_clr;
  logic                 slice_en;
  logic signed [DW-1:0] p_s   [4];
  logic signed [AW-1:0] term  [4];
  logic signed [AW-1:0] acc_d [4];
  logic signed [AW-1:0] acc_q [4];
  logic signed [AW-1:0] sum_d;
  logic signed [AW-1:0] total_q;
  logic                 out_valid_q;
  logic                 busy_q;

  assign slice_clr = (state_q == IDLE) && bus.start;
  assign slice_en  = (state_q == ACCUM) && bus.in_valid;

  da_slice_ctr #(
    .BITS (BITS),
    .CW   (CW)
  ) u_slice_ctr (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (slice_clr),
    .en_i     (slice_en),
    .active_i (state_q == ACCUM),
    .cnt_o    (cnt),
    .last_o   (last),
    .t_o      (bus.t),
    .sign_o   (bus.sign)
  );

  // The MSB slice carries negative weight in two's complement.
  always_comb begin
    p_s[0] = bus.p2;
    p_s[1] = bus.p3;
    p_s[2] = bus.p4;
    p_s[3] = bus.p5;
    sum_d  = '0;
    for (int k = 0; k < 4; k++) begin
      term[k]  = AW'(p_s[k]) <<< cnt;
      acc_d[k] = last ? (acc_q[k] - term[k]) : (acc_q[k] + term[k]);
      sum_d    = sum_d + acc_d[k];
    end
  end

  // total is written with the last slice so it is already valid during DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      total_q     <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        acc_q[k] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          out_valid_q <= 1'b0;
          if (bus.start) begin
            state_q <= ACCUM;
            busy_q  <= 1'b1;
            for (int k = 0; k < 4; k++) begin
              acc_q[k] <= '0;
            end
          end
        end
        ACCUM: begin
          if (bus.in_valid) begin
            for (int k = 0; k < 4; k++) begin
              acc_q[k] <= acc_d[k];
            end
            if (last) begin
              state_q     <= DONE;
              total_q     <= sum_d;
              out_valid_q <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.acc2      = acc_q[0];
  assign bus.acc3      = acc_q[1];
  assign bus.acc4      = acc_q[2];
  assign bus.acc5      = acc_q[3];
  assign bus.total     = total_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_da_shift_accum.sv
// tb/tb_da_shift_accum.sv - self-checking bench for da_shift_accum against a weighted-sum reference model
module tb_da_shift_accum;

  localparam int BITS = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  da_shift_accum_if bus ();

  da_shift_accum dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks   = 0;
  int failures = 0;
  int pv [4][BITS];

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Sample value = sum of slice_s * 2^s, with the top slice weighted negatively.
  function automatic int model_acc(input int k);
    int a;
    a = 0;
    for (int s = 0; s < BITS; s++) begin
      if (s == BITS - 1) a = a - pv[k][s] * (1 << s);
      else               a = a + pv[k][s] * (1 << s);
    end
    return a;
  endfunction

  task automatic drive_idle();
    bus.in_valid = 1'b0;
    bus.p2 = '0;
    bus.p3 = '0;
    bus.p4 = '0;
    bus.p5 = '0;
  endtask

  task automatic drive_slice(input int s);
    bus.in_valid = 1'b1;
    bus.p2 = 8'(pv[0][s]);
    bus.p3 = 8'(pv[1][s]);
    bus.p4 = 8'(pv[2][s]);
    bus.p5 = 8'(pv[3][s]);
  endtask

  task automatic fill(input int v);
    for (int k = 0; k < 4; k++)
      for (int s = 0; s < BITS; s++) pv[k][s] = v;
  endtask

  task automatic fill_random();
    for (int k = 0; k < 4; k++)
      for (int s = 0; s < BITS; s++) pv[k][s] = int'($urandom_range(255)) - 128;
  endtask

  task automatic run_sample(input string name, input int stall_at, input int stall_n,
                            input int glitch_at);
    int cyc;
    bit seen;
    int exp_tot;
    @(negedge clk);
    bus.start = 1'b1;
    cyc = 0;
    for (int s = 0; s < BITS; s++) begin
      if (s == stall_at) begin
        for (int i = 0; i < stall_n; i++) begin
          @(negedge clk);
          cyc++;
          bus.start    = 1'b0;
          bus.in_valid = 1'b0;
          bus.p2       = 8'($urandom);
          check({name, " stall t"}, int'(bus.t), s);
          check({name, " stall out_valid"}, int'(bus.out_valid), 0);
        end
      end
      @(negedge clk);
      cyc++;
      bus.start = (s == glitch_at);
      check({name, " t"}, int'(bus.t), s);
      check({name, " sign"}, int'(bus.sign), (s == BITS - 1) ? 1 : 0);
      check({name, " busy"}, int'(bus.busy), 1);
      drive_slice(s);
    end
    seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      @(negedge clk);
      cyc++;
      bus.start = 1'b0;
      drive_idle();
      if (bus.out_valid === 1'b1) seen = 1'b1;
    end
    check({name, " out_valid seen"}, int'(seen), 1);
    check({name, " latency"}, cyc, BITS + 1 + stall_n);
    check({name, " acc2"}, int'(bus.acc2), model_acc(0));
    check({name, " acc3"}, int'(bus.acc3), model_acc(1));
    check({name, " acc4"}, int'(bus.acc4), model_acc(2));
    check({name, " acc5"}, int'(bus.acc5), model_acc(3));
    exp_tot = model_acc(0) + model_acc(1) + model_acc(2) + model_acc(3);
    check({name, " total"}, int'(bus.total), exp_tot);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check({name, " out_valid pulse"}, int'(bus.out_valid), 0);
    check({name, " start in DONE ignored"}, int'(bus.busy), 0);
    check({name, " total hold"}, int'(bus.total), exp_tot);
    check({name, " acc2 hold"}, int'(bus.acc2), model_acc(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;
    drive_idle();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset t", int'(bus.t), 0);
    check("reset sign", int'(bus.sign), 0);
    check("reset busy", int'(bus.busy), 0);
    check("reset out_valid", int'(bus.out_valid), 0);
    check("reset acc2", int'(bus.acc2), 0);
    check("reset acc3", int'(bus.acc3), 0);
    check("reset acc4", int'(bus.acc4), 0);
    check("reset acc5", int'(bus.acc5), 0);
    check("reset total", int'(bus.total), 0);
    rst = 1'b0;

    fill(1);
    run_sample("ones", -1, 0, -1);
    check("ones acc2 literal", int'(bus.acc2), -1);
    check("ones total literal", int'(bus.total), -4);

    fill(0);
    pv[0][0] = 5;
    pv[1][2] = -3;
    run_sample("single", -1, 0, -1);
    check("single acc3 literal", int'(bus.acc3), -12);
    check("single total literal", int'(bus.total), -7);

    fill(-128);
    run_sample("extreme", -1, 0, -1);
    check("extreme total literal", int'(bus.total), 512);

    fill(1);
    run_sample("stall", 5, 3, -1);

    fill_random();
    run_sample("glitch", -1, 0, 3);

    // Abort a sample at slice 3 and verify nothing leaks into the next one.
    fill_random();
    @(negedge clk);
    bus.start = 1'b1;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      bus.start = 1'b0;
      drive_slice(s);
    end
    @(negedge clk);
    check("abort t before reset", int'(bus.t), 3);
    drive_slice(3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive_idle();
    check("abort busy", int'(bus.busy), 0);
    check("abort t", int'(bus.t), 0);
    check("abort sign", int'(bus.sign), 0);
    check("abort acc2", int'(bus.acc2), 0);
    check("abort total", int'(bus.total), 0);
    check("abort out_valid", int'(bus.out_valid), 0);
    fill(0);
    pv[0][0] = 1;
    run_sample("after abort", -1, 0, -1);
    check("after abort acc2 literal", int'(bus.acc2), 1);

    for (int r = 0; r < 3; r++) begin
      fill_random();
      run_sample($sformatf("random%0d", r), int'($urandom_range(BITS - 1, 1)),
                 int'($urandom_range(2)), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
